// File: rtl/ir_coeff_bank.sv
// Double-buffered FIR coefficient store: host streams a new impulse response into
// the shadow bank while the FIR reads the active bank; banks swap on frame_sync.
module ir_coeff_bank #(
    parameter int               TAPS  = 256,
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] UNITY = 16'h4000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start_i,
    input  logic                    ld_valid_i,
    output logic                    ld_ready_o,
    input  logic [WIDTH-1:0]        ld_data_i,
    input  logic                    swap_req_i,
    input  logic                    frame_sync_i,
    input  logic                    rd_en_i,
    input  logic [$clog2(TAPS)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]        rd_data_o,
    output logic                    active_slot_o,
    output logic                    shadow_full_o,
    output logic                    swap_pending_o,
    output logic                    swap_done_o
);

    localparam int AW = $clog2(TAPS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;
    localparam logic [1:0] S_PENDING = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          active_slot_q, active_slot_d;
    logic          active_valid_q, active_valid_d;
    logic          swap_done_q, swap_done_d;
    logic          commit;
    logic          wr_en;

    logic [WIDTH-1:0] mem_q [2*TAPS];
    logic [WIDTH-1:0] ram_rd_q;
    logic             rd_imp_q;
    logic             rd_unity_q;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        active_slot_d  = active_slot_q;
        active_valid_d = active_valid_q;
        swap_done_d    = 1'b0;
        commit         = 1'b0;
        wr_en          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load_start_i) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                end
            end
            S_LOAD: begin
                // A restart wins over a coincident transfer, which is dropped.
                if (load_start_i) begin
                    wr_ptr_d = '0;
                end else if (ld_valid_i) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (&wr_ptr_q) state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (load_start_i) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                end else if (swap_req_i) begin
                    if (frame_sync_i) commit = 1'b1;
                    else              state_d = S_PENDING;
                end
            end
            S_PENDING: begin
                if (load_start_i) begin
                    state_d  = S_LOAD;
                    wr_ptr_d = '0;
                end else if (frame_sync_i) begin
                    commit = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            state_d        = S_IDLE;
            active_slot_d  = ~active_slot_q;
            active_valid_d = 1'b1;
            swap_done_d    = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            active_slot_q  <= 1'b0;
            active_valid_q <= 1'b0;
            swap_done_q    <= 1'b0;
            rd_imp_q       <= 1'b1;
            rd_unity_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            active_slot_q  <= active_slot_d;
            active_valid_q <= active_valid_d;
            swap_done_q    <= swap_done_d;
            if (rd_en_i) begin
                rd_imp_q   <= ~active_valid_q;
                rd_unity_q <= (rd_addr_i == '0);
            end
        end
    end

    // NOTE: the coefficient RAM is deliberately not reset; rd_imp_q masks it until a bank is committed.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[{~active_slot_q, wr_ptr_q}] <= ld_data_i;
        if (rd_en_i) ram_rd_q <= mem_q[{active_slot_q, rd_addr_i}];
    end

    assign rd_data_o      = rd_imp_q ? (rd_unity_q ? UNITY : '0) : ram_rd_q;
    assign ld_ready_o     = (state_q == S_LOAD);
    assign shadow_full_o  = (state_q == S_FULL) || (state_q == S_PENDING);
    assign swap_pending_o = (state_q == S_PENDING);
    assign swap_done_o    = swap_done_q;
    assign active_slot_o  = active_slot_q;

endmodule
